// File: rtl/power_isqrt.sv
// rtl/power_isqrt.sv - iterative radix-2 integer square root with remainder
//
// Purpose: accepts a 2*DATA_WIDTH-bit unsigned radicand and produces its
// floor square root and remainder, one root bit per clock.
//
// Ports:
//   clk      system clock, all state changes on the rising edge
//   reset    synchronous active-high reset
//   i_valid  radicand valid
//   i_data   unsigned radicand (2*DATA_WIDTH bits)
//   o_ready  block can accept a radicand this cycle
//   o_valid  one-cycle result strobe per accepted radicand
//   o_data   floor(sqrt(radicand)) (DATA_WIDTH bits)
//   o_rem    radicand - o_data*o_data (DATA_WIDTH+1 bits)
//   o_exact  remainder is zero
module power_isqrt #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_valid,
  input  logic [2*DATA_WIDTH-1:0]   i_data,
  output logic                      o_ready,
  output logic                      o_valid,
  output logic [DATA_WIDTH-1:0]     o_data,
  output logic [DATA_WIDTH:0]       o_rem,
  output logic                      o_exact
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [2*DATA_WIDTH-1:0] radicand;
  logic [DATA_WIDTH+1:0]   rem;
  logic [DATA_WIDTH+1:0]   r2;
  logic [DATA_WIDTH+1:0]   trial;
  logic [DATA_WIDTH+1:0]   rem_nxt;
  logic [DATA_WIDTH-1:0]   root;
  logic [DATA_WIDTH-1:0]   root_nxt;
  logic [CW-1:0]           cnt;
  logic                    accept;
  logic                    ge;
  logic                    last;

  assign accept = i_valid && o_ready;
  assign last   = (state == CALC) && (cnt == '0);

  // One digit step: bring down the next radicand bit pair and try to
  // subtract (4*root + 1). The remainder never exceeds 2*root, so the
  // shifted value fits in DATA_WIDTH+2 bits.
  always_comb begin
    r2       = {rem[DATA_WIDTH-1:0], radicand[2*DATA_WIDTH-1 -: 2]};
    trial    = {root, 2'b01};
    ge       = (r2 >= trial);
    rem_nxt  = ge ? (r2 - trial) : r2;
    root_nxt = {root[DATA_WIDTH-2:0], ge};
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: if (cnt == '0) state_nxt = DONE;
      DONE: state_nxt = accept ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic; DONE lasts exactly one cycle, so it doubles as the strobe
  always_comb begin
    o_ready = !reset && ((state == IDLE) || (state == DONE));
    o_valid = (state == DONE);
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      radicand <= '0;
      rem      <= '0;
      root     <= '0;
      cnt      <= '0;
      o_data   <= '0;
      o_rem    <= '0;
      o_exact  <= 1'b0;
    end else if (accept) begin
      radicand <= i_data;
      rem      <= '0;
      root     <= '0;
      cnt      <= CW'(DATA_WIDTH - 1);
    end else if (state == CALC) begin
      radicand <= radicand << 2;
      rem      <= rem_nxt;
      root     <= root_nxt;
      if (last) begin
        // Results are captured from the final step directly so they are
        // visible in the same cycle as the strobe.
        o_data  <= root_nxt;
        o_rem   <= rem_nxt[DATA_WIDTH:0];
        o_exact <= (rem_nxt == '0);
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_power_isqrt.sv
// tb/tb_power_isqrt.sv - directed self-checking bench for power_isqrt
module tb_power_isqrt;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_valid;
  logic [2*DW-1:0] i_data;
  logic          o_ready;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic [DW:0]   o_rem;
  logic          o_exact;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] hv [4];
  logic [31:0] hr [4];
  logic [31:0] cv [5];

  power_isqrt #(.DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_rem   (o_rem),
    .o_exact (o_exact)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!o_ready && n < 200) begin
      step();
      n++;
    end
    check({tag, "_ready"}, 64'(o_ready), 64'd1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!o_valid && lat < 100) begin
      step();
      lat++;
    end
  endtask

  task automatic run_one(input string tag, input logic [63:0] x, input logic [31:0] er,
                         input logic [32:0] erem, input logic ee);
    int lat;
    wait_ready(tag);
    i_valid = 1'b1;
    i_data  = x;
    step();
    i_valid = 1'b0;
    check({tag, "_busy"}, 64'(o_ready), 64'd0);
    wait_valid(lat);
    check({tag, "_lat"}, 64'(lat), 64'd32);
    check({tag, "_root"}, 64'(o_data), 64'(er));
    check({tag, "_rem"}, 64'(o_rem), 64'(erem));
    check({tag, "_exact"}, 64'(o_exact), 64'(ee));
    step();
    check({tag, "_pulse"}, 64'(o_valid), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nv;
    logic [31:0] vd;
    logic [63:0] sq;

    hv[0] = 64'd9;  hv[1] = 64'd25; hv[2] = 64'd49; hv[3] = 64'd100;
    hr[0] = 32'd3;  hr[1] = 32'd5;  hr[2] = 32'd7;  hr[3] = 32'd10;
    cv[0] = 32'd2;  cv[1] = 32'd3;  cv[2] = 32'd5;  cv[3] = 32'd7;  cv[4] = 32'hA;

    reset   = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    step();
    check("rst_ready", 64'(o_ready), 64'd0);
    step();
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_data", 64'(o_data), 64'd0);
    check("rst_rem", 64'(o_rem), 64'd0);
    check("rst_exact", 64'(o_exact), 64'd0);
    reset = 1'b0;
    #1;
    check("rst_release_ready", 64'(o_ready), 64'd1);

    run_one("sq4", 64'h4, 32'd2, 33'd0, 1'b1);

    // Back-to-back with i_valid held high: each DONE exit edge accepts the next
    wait_ready("held");
    i_valid = 1'b1;
    i_data  = hv[0];
    step();
    for (int k = 0; k < 4; k++) begin
      int lat;
      if (k < 3) i_data = hv[k+1];
      else i_valid = 1'b0;
      wait_valid(lat);
      check("held_lat", 64'(lat), 64'd32);
      check("held_root", 64'(o_data), 64'(hr[k]));
      check("held_rem", 64'(o_rem), 64'd0);
      check("held_exact", 64'(o_exact), 64'd1);
      step();
      check("held_pulse", 64'(o_valid), 64'd0);
      if (k < 3) check("held_reaccept", 64'(o_ready), 64'd0);
      else check("held_idle", 64'(o_ready), 64'd1);
    end

    run_one("ones", 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE, 1'b0);
    run_one("zero", 64'h0, 32'h0, 33'h0, 1'b1);
    run_one("n99", 64'd99, 32'd9, 33'd18, 1'b0);
    run_one("pow62", 64'h4000_0000_0000_0000, 32'h8000_0000, 33'h0, 1'b1);

    // Requests while busy must be ignored
    wait_ready("ign");
    i_valid = 1'b1;
    i_data  = 64'd100;
    step();
    i_valid = 1'b0;
    nv = 0;
    vd = '0;
    for (int c = 1; c <= 60; c++) begin
      i_valid = (c == 5) || (c == 20);
      i_data  = 64'd49;
      step();
      if (o_valid) begin
        nv++;
        vd = o_data;
      end
    end
    i_valid = 1'b0;
    check("ign_count", 64'(nv), 64'd1);
    check("ign_root", 64'(vd), 64'd10);

    // Reset mid-CALC, with i_valid asserted alongside reset
    wait_ready("abort");
    i_valid = 1'b1;
    i_data  = 64'd49;
    step();
    i_valid = 1'b0;
    repeat (10) step();
    reset   = 1'b1;
    i_valid = 1'b1;
    i_data  = 64'd25;
    #1;
    check("abort_ready_in_reset", 64'(o_ready), 64'd0);
    step();
    reset   = 1'b0;
    i_valid = 1'b0;
    #1;
    check("abort_valid", 64'(o_valid), 64'd0);
    check("abort_data", 64'(o_data), 64'd0);
    check("abort_rem", 64'(o_rem), 64'd0);
    check("abort_exact", 64'(o_exact), 64'd0);
    check("abort_ready", 64'(o_ready), 64'd1);
    nv = 0;
    repeat (40) begin
      step();
      if (o_valid) nv++;
    end
    check("abort_no_valid", 64'(nv), 64'd0);
    run_one("after_abort", 64'd25, 32'd5, 33'd0, 1'b1);

    // Squaring stage modelled in the bench, then closed through the root
    for (int k = 0; k < 5; k++) begin
      sq = 64'(cv[k]) * 64'(cv[k]);
      run_one("chain", sq, cv[k], 33'd0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/power_isqrt.md
Name: power_isqrt

Overview:
- Inverse companion to the power (squaring) pipeline: takes a 2*DATA_WIDTH-bit unsigned value and returns its integer square root and remainder.
- Sits downstream of power's o_valid/o_data and closes the loop: isqrt(x*x) == x.
- Iterative radix-2 digit-by-digit engine, one root bit per clock.
- Input valid/ready handshake; one-cycle result strobe on the output.

Parameters:
- DATA_WIDTH, 32, root width; input width is 2*DATA_WIDTH; remainder width is DATA_WIDTH+1.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- i_valid  input  1  input data valid
- i_data  input  2*DATA_WIDTH  unsigned radicand
- o_ready  output  1  block can accept a radicand this cycle
- o_valid  output  1  result strobe, high exactly one cycle per accepted radicand
- o_data  output  DATA_WIDTH  floor(sqrt(i_data))
- o_rem  output  DATA_WIDTH+1  i_data - o_data*o_data
- o_exact  output  1  o_rem == 0

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high; it takes effect on the rising edge of clk.
- Reset values: state IDLE; o_valid=0, o_data=0, o_rem=0, o_exact=0. o_ready is forced 0 while reset is high.
- States: IDLE, CALC, DONE.
- o_ready = !reset && (state==IDLE || state==DONE).
- Accept: i_valid && o_ready at a rising edge.
  - Latch i_data into the radicand shift register; clear the internal rem (DATA_WIDTH+2 bits) and the root register.
  - Load the iteration counter with DATA_WIDTH-1; go to CALC.
  - When o_ready=0, i_valid and i_data are ignored.
- CALC, once per edge:
  - r2 = (rem<<2) | radicand[2*DATA_WIDTH-1 -: 2]; radicand <<= 2; trial = (root<<2)|1.
  - If r2 >= trial: rem = r2 - trial, root = (root<<1)|1. Else: rem = r2, root = root<<1.
  - When counter==0, perform the final iteration and go to DONE; otherwise decrement the counter.
- DONE entry edge: register o_data=root, o_rem=rem[DATA_WIDTH:0], o_exact=(rem==0), and set o_valid=1.
- Latency: o_valid is high in the cycle following the DATA_WIDTH-th rising edge after the accepting edge (32 for the default). It lasts exactly one cycle.
- DONE exit edge: o_valid falls. If i_valid=1, the new radicand is accepted and the state goes directly to CALC; otherwise the state goes to IDLE.
- Throughput with i_valid held high: one result every DATA_WIDTH+1 cycles.
- No output backpressure: the consumer must take the result on the o_valid cycle.
- o_data, o_rem and o_exact hold their last result until the next DONE entry. They are not cleared when o_valid falls.
- Arithmetic is unsigned throughout. The remainder is bounded by 2*root, so DATA_WIDTH+1 bits never overflow. The internal compare/subtract uses DATA_WIDTH+2 bits.
- Boundary cases:
  - i_data=0 yields root 0, rem 0, exact 1.
  - All-ones input yields root all-ones, rem 2*(2^DATA_WIDTH-1).
- Reset mid-CALC or in DONE aborts the operation. No o_valid is produced for the aborted radicand, and outputs return to their reset values.
- Simultaneous reset and i_valid: reset wins and nothing is accepted.

Test Plan:
- Reset 2 cycles, then i_data=64'h4 -> o_ready falls on the next edge; exactly 32 cycles later o_valid=1 for one cycle with o_data=2, o_rem=0, o_exact=1.
- i_valid held high with i_data updated on each accept to 9, 25, 49, 100 -> accepts spaced 33 cycles apart; results 3, 5, 7, 0xA in order, all exact, rem 0.
- i_data=64'hFFFF_FFFF_FFFF_FFFF -> o_data=32'hFFFF_FFFF, o_rem=33'h1_FFFF_FFFE, o_exact=0. Then i_data=0 -> o_data=0, o_rem=0, o_exact=1.
- i_data=99 -> o_data=9, o_rem=18, o_exact=0. i_data=64'h4000_0000_0000_0000 -> o_data=32'h8000_0000, o_rem=0.
- Accept 100, pulse i_valid with 49 at cycles 5 and 20 while busy -> both ignored; single o_valid with o_data=0xA.
- Accept 49, assert reset at cycle 10 of CALC for 1 cycle -> no o_valid, outputs 0, o_ready=1 after release; next radicand 25 -> o_data=5 after 32 cycles.
- Chain power(DATA_WIDTH=32) -> power_isqrt for inputs 2, 3, 5, 7, 0xA -> o_data equals the original input and o_exact=1 for each.
